universal_shift_register: RTL and testbench

//  Parametrised WIDTH-bit register bank built on edge-triggered D storage with a mode-selected next state.

---
 rtl/universal_shift_register.sv | 86 ++++++++
 tb/tb_universal_shift_register.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift, rotate, arithmetic shift, load, sync clear.
// Define USR_NEGEDGE_EN to update on the falling clock edge; clear stays asynchronous either way.
module universal_shift_register #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             sout,
   output logic             zero
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_SCLR = 3'b111;

   logic [WIDTH-1:0] q_nxt;
   logic             sout_nxt;

   generate
      if (WIDTH == 1) begin : g_w1
         // A single bit cannot be reordered, so rotates and ASR keep q but still report it on sout.
         always_comb begin
            q_nxt    = q;
            sout_nxt = sout;
            case (mode)
               MODE_HOLD: ;
               MODE_SHR:  begin q_nxt = sin_r; sout_nxt = q[0]; end
               MODE_SHL:  begin q_nxt = sin_l; sout_nxt = q[0]; end
               MODE_LOAD: q_nxt = d;
               MODE_ROR:  sout_nxt = q[0];
               MODE_ROL:  sout_nxt = q[0];
               MODE_ASR:  sout_nxt = q[0];
               MODE_SCLR: begin q_nxt = RESET_VALUE; sout_nxt = 1'b0; end
               default:   ;
            endcase
         end
      end else begin : g_wn
         always_comb begin
            q_nxt    = q;
            sout_nxt = sout;
            case (mode)
               MODE_HOLD: ;
               MODE_SHR:  begin q_nxt = {sin_r, q[WIDTH-1:1]};    sout_nxt = q[0];       end
               MODE_SHL:  begin q_nxt = {q[WIDTH-2:0], sin_l};    sout_nxt = q[WIDTH-1]; end
               MODE_LOAD: q_nxt = d;
               MODE_ROR:  begin q_nxt = {q[0], q[WIDTH-1:1]};     sout_nxt = q[0];       end
               MODE_ROL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; sout_nxt = q[WIDTH-1]; end
               MODE_ASR:  begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; sout_nxt = q[0];     end
               MODE_SCLR: begin q_nxt = RESET_VALUE; sout_nxt = 1'b0; end
               default:   ;
            endcase
         end
      end
   endgenerate

`ifdef USR_NEGEDGE_EN
   always_ff @(negedge clk or posedge clear) begin
`else
   always_ff @(posedge clk or posedge clear) begin
`endif
      if (clear) begin
         q    <= RESET_VALUE;
         sout <= 1'b0;
      end else if (en) begin
         q    <= q_nxt;
         sout <= sout_nxt;
      end
   end

   assign nq   = ~q;
   assign zero = (q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=8, RESET_VALUE=0).
// Follows USR_NEGEDGE_EN so stimulus and sampling track the DUT's active edge.
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       clear;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_r;
   logic       sin_l;
   logic [7:0] q;
   logic [7:0] nq;
   logic       sout;
   logic       zero;

   int checks = 0;
   int errors = 0;

   universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
      .clk   (clk),
      .clear (clear),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .sin_r (sin_r),
      .sin_l (sin_l),
      .q     (q),
      .nq    (nq),
      .sout  (sout),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   task automatic active_edge();
`ifdef USR_NEGEDGE_EN
      @(negedge clk);
`else
      @(posedge clk);
`endif
      #1;
   endtask

   task automatic inactive_edge();
`ifdef USR_NEGEDGE_EN
      @(posedge clk);
`else
      @(negedge clk);
`endif
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic sr, input logic sl);
      en = 1'b1; mode = m; d = dv; sin_r = sr; sin_l = sl;
      active_edge();
   endtask

   initial begin
      clear = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
      #2;
      chk("rst_q", q, 8'h00);
      chk("rst_nq", nq, 8'hFF);
      chk("rst_zero", {7'b0, zero}, 8'h01);
      chk("rst_sout", {7'b0, sout}, 8'h00);
      active_edge();
      clear = 1'b0;

      // async clear with sout=1 and q=A5
      op(3'b011, 8'h81, 0, 0);
      op(3'b100, 8'h00, 0, 0);
      op(3'b011, 8'hA5, 0, 0);
      chk("pre_clr_q", q, 8'hA5);
      chk("pre_clr_sout", {7'b0, sout}, 8'h01);
      #2;
      clear = 1'b1;
      #1;
      chk("clr_q", q, 8'h00);
      chk("clr_nq", nq, 8'hFF);
      chk("clr_zero", {7'b0, zero}, 8'h01);
      chk("clr_sout", {7'b0, sout}, 8'h00);
      en = 1'b1; mode = 3'b011; d = 8'h5A;
      active_edge();
      chk("clr_hold_edge", q, 8'h00);
      clear = 1'b0;

      // rotate
      op(3'b011, 8'h81, 0, 0);
      chk("load81", q, 8'h81);
      chk("load_nq", nq, 8'h7E);
      chk("load_zero", {7'b0, zero}, 8'h00);
      op(3'b100, 8'h00, 0, 0);
      chk("ror_q", q, 8'hC0);
      chk("ror_sout", {7'b0, sout}, 8'h01);
      op(3'b101, 8'h00, 0, 0);
      chk("rol1_q", q, 8'h81);
      chk("rol1_sout", {7'b0, sout}, 8'h01);
      for (int i = 0; i < 7; i++) op(3'b101, 8'h00, 0, 0);
      chk("rol8_q", q, 8'hC0);
      op(3'b000, 8'hFF, 1, 1);
      chk("hold_q", q, 8'hC0);

      // arithmetic and logical right shift
      op(3'b011, 8'h80, 0, 0);
      for (int i = 0; i < 3; i++) op(3'b110, 8'h00, 0, 0);
      chk("asr3_q", q, 8'hF0);
      chk("asr3_sout", {7'b0, sout}, 8'h00);
      op(3'b001, 8'h00, 0, 0);
      chk("shr_q", q, 8'h78);
      chk("shr_sout", {7'b0, sout}, 8'h00);
      op(3'b001, 8'h00, 1, 0);
      chk("shr_sin1_q", q, 8'hBC);
      op(3'b011, 8'h03, 0, 0);
      op(3'b001, 8'h00, 0, 0);
      chk("shr_out1_q", q, 8'h01);
      chk("shr_out1_sout", {7'b0, sout}, 8'h01);

      // left shift fill
      op(3'b011, 8'h01, 0, 0);
      op(3'b010, 8'h00, 0, 1);
      chk("shl1_q", q, 8'h03);
      chk("shl1_sout", {7'b0, sout}, 8'h00);
      for (int i = 0; i < 7; i++) op(3'b010, 8'h00, 0, 1);
      chk("shl8_q", q, 8'hFF);
      chk("shl8_sout", {7'b0, sout}, 8'h01);

      // enable gating
      en = 1'b0; mode = 3'b011; d = 8'h3C;
      for (int i = 0; i < 4; i++) active_edge();
      chk("en0_q", q, 8'hFF);
      chk("en0_sout", {7'b0, sout}, 8'h01);
      op(3'b011, 8'h3C, 0, 0);
      chk("en1_q", q, 8'h3C);
      chk("load_sout_hold", {7'b0, sout}, 8'h01);

      // edge sense
      en = 1'b1; mode = 3'b011; d = 8'h55;
      inactive_edge();
      chk("inactive_edge_q", q, 8'h3C);
      active_edge();
      chk("active_edge_q", q, 8'h55);

      op(3'b111, 8'hFF, 1, 1);
      chk("sclr_q", q, 8'h00);
      chk("sclr_zero", {7'b0, zero}, 8'h01);
      chk("sclr_sout", {7'b0, sout}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
